// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage data memory controller: RV32I
// load/store funct3 encodings, controller state type and access legality.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_e;

    // An access is legal when it is a single load or store of a supported
    // size, naturally aligned for that size.
    function automatic logic dmem_legal(
        input logic       rd,
        input logic       wr,
        input logic [2:0] f3,
        input logic [1:0] lo
    );
        logic ok;
        ok = 1'b1;
        if (rd && wr)                       ok = 1'b0;
        if (f3 == 3'b011 || f3[2:1] == 2'b11) ok = 1'b0;
        if (wr && f3[2])                    ok = 1'b0;
        if (f3[1:0] == 2'b01 && lo[0])      ok = 1'b0;
        if (f3[1:0] == 2'b10 && lo != 2'b00) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane handling for the data memory port: store data replication and
// strobe generation, load lane extraction with sign/zero extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lane,
    input  logic [31:0] i_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Replicate store data across lanes so any lane selected by the strobe sees it.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'h0;
        case (i_st_size)
            2'b00: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_lane;
            end
            2'b01: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = 4'b0011 << i_st_lane;
            end
            2'b10: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'hF;
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'h0;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the returned word.
    always_comb begin
        case (i_ld_lane)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    end

    // Extend the selected lane to 32 bits according to the load type.
    always_comb begin
        case (i_ld_funct3)
            F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            F3_LW:   o_ld_data = i_ld_word;
            F3_LBU:  o_ld_data = {24'h0, w_byte};
            F3_LHU:  o_ld_data = {16'h0, w_half};
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: sequences one access at a time onto a
// variable-latency data bus, stalls the pipeline while it is in flight and
// reports misaligned/illegal accesses and bus timeouts as one-cycle pulses.
//
// state | meaning
// IDLE  | nothing in flight; decode the M-stage instruction
// REQ   | request presented on the bus, waiting for grant
// WAIT  | granted, waiting for the response
// DONE  | access retired; stall released, Exc/BusErr pulse
module dmem_access_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallMemM,
    output logic [31:0] ReadDataM,
    output logic        ExcM,
    output logic        BusErrM,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    dmem_state_e     r_state;
    dmem_state_e     w_next;

    logic [TO_W-1:0] r_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [3:0]      r_wstrb;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [31:0]     r_rdata;
    logic            r_exc;
    logic            r_berr;

    logic            w_access;
    logic            w_legal;
    logic            w_start;
    logic            w_illegal;
    logic            w_busy;
    logic            w_resp;
    logic            w_timeout;
    logic [31:0]     w_st_wdata;
    logic [3:0]      w_st_wstrb;
    logic [31:0]     w_ld_data;

    assign w_access  = MemReadM | MemWriteM;
    assign w_legal   = dmem_legal(MemReadM, MemWriteM, funct3M, ALUResultM[1:0]);
    assign w_start   = (r_state == ST_IDLE) & w_access & w_legal;
    assign w_illegal = (r_state == ST_IDLE) & w_access & ~w_legal;
    assign w_busy    = (r_state == ST_REQ) | (r_state == ST_WAIT);
    // A response only counts once the request has been granted; anything
    // arriving in IDLE/DONE (e.g. after a reset or timeout) is dropped.
    assign w_resp    = mem_rvalid & (((r_state == ST_REQ) & mem_gnt) | (r_state == ST_WAIT));
    // A response in the final allowed cycle still completes normally.
    assign w_timeout = w_busy & ~w_resp & (r_cnt == CNT_LAST);

    lsu_align u_align (
        .i_st_size   (funct3M[1:0]),
        .i_st_lane   (ALUResultM[1:0]),
        .i_st_data   (WriteDataM),
        .i_ld_funct3 (r_funct3),
        .i_ld_lane   (r_lane),
        .i_ld_word   (mem_rdata),
        .o_st_wdata  (w_st_wdata),
        .o_st_wstrb  (w_st_wstrb),
        .o_ld_data   (w_ld_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start)        w_next = ST_REQ;
                else if (w_illegal) w_next = ST_DONE;
            end
            ST_REQ: begin
                if (w_resp || w_timeout) w_next = ST_DONE;
                else if (mem_gnt)        w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_resp || w_timeout) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Bus and stall outputs; bus fields are only driven while requesting.
    // An illegal access does not stall: the exception flushes the younger
    // instruction that reaches M during the DONE cycle.
    always_comb begin
        StallMemM = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        case (r_state)
            ST_IDLE: StallMemM = w_start;
            ST_REQ: begin
                StallMemM = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                mem_wstrb = r_wstrb;
            end
            ST_WAIT: StallMemM = 1'b1;
            default: StallMemM = 1'b0;
        endcase
    end

    assign ReadDataM = r_rdata;
    assign ExcM      = r_exc;
    assign BusErrM   = r_berr;

    // Timeout counter: restarts with each accepted access, runs while in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Request capture, load result and the one-cycle Exc/BusErr flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_lane   <= '0;
            r_rdata  <= '0;
            r_exc    <= 1'b0;
            r_berr   <= 1'b0;
        end else begin
            r_exc  <= w_illegal;
            r_berr <= w_timeout;
            if (w_start) begin
                r_addr   <= {ALUResultM[31:2], 2'b00};
                r_we     <= MemWriteM;
                r_wdata  <= w_st_wdata;
                r_wstrb  <= MemWriteM ? w_st_wstrb : 4'h0;
                r_funct3 <= funct3M;
                r_lane   <= ALUResultM[1:0];
                r_rdata  <= '0;
            end else if (w_illegal || w_timeout) begin
                r_rdata  <= '0;
            end else if (w_resp) begin
                r_rdata  <= r_we ? 32'h0 : w_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Testbench for dmem_access_ctrl: directed vector table, random accesses
// against a behavioural model, plus timeout and reset-during-access sequences.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 64;
    localparam int BUDGET  = 300;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic        StallMemM;
    logic [31:0] ReadDataM;
    logic        ExcM;
    logic        BusErrM;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .StallMemM  (StallMemM),
        .ReadDataM  (ReadDataM),
        .ExcM       (ExcM),
        .BusErrM    (BusErrM),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog");
    end

    // gw: REQ cycles before grant; rw: cycles from grant to rvalid (0 = same cycle)
    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          gw;
        int          rw;
    } acc_t;

    typedef struct {
        int          stall;
        logic        exc;
        logic        berr;
        logic [31:0] rdat;
        logic        ld;
        logic        req;
        logic [31:0] maddr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } exp_t;

    typedef struct {
        acc_t a;
        exp_t e;
    } vec_t;

    typedef struct {
        int          stall;
        logic        exc_done;
        int          exc_n;
        logic        berr_done;
        int          berr_n;
        logic [31:0] rdat;
        int          req_n;
        logic [31:0] maddr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        unstable;
        logic        hung;
    } res_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    // Behavioural reference: legality from size/alignment, lane math by arithmetic.
    function automatic exp_t model(input acc_t a);
        exp_t        e;
        int          bytes;
        int          off;
        int          total;
        logic        legal;
        logic [31:0] v;
        bytes = (a.f3[1:0] == 2'd0) ? 1 : (a.f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(a.addr & 32'd3);
        legal = (a.rd != a.wr) && (a.f3 != 3'd3) && (a.f3 != 3'd6) && (a.f3 != 3'd7)
                && !(a.wr && a.f3 >= 3'd4) && ((off % bytes) == 0);
        e.ld    = a.rd;
        e.req   = legal;
        e.exc   = !legal;
        e.berr  = 1'b0;
        e.maddr = a.addr & 32'hFFFF_FFFC;
        e.we    = a.wr;
        e.strb  = a.wr ? 4'(((1 << bytes) - 1) << off) : 4'h0;
        if (bytes == 1)      e.wdata = (a.wd & 32'hFF) * 32'h0101_0101;
        else if (bytes == 2) e.wdata = (a.wd & 32'hFFFF) * 32'h0001_0001;
        else                 e.wdata = a.wd;
        e.stall = 0;
        e.rdat  = 32'h0;
        if (legal) begin
            total = a.gw + 1 + a.rw;
            if (total > TIMEOUT) begin
                e.berr  = 1'b1;
                e.stall = 1 + TIMEOUT;
            end else begin
                e.stall = total + 1;
                v = a.rdata >> (8 * off);
                if (bytes == 1) begin
                    v = v & 32'hFF;
                    if (a.f3 < 3'd4 && v >= 32'd128) v = v + 32'hFFFF_FF00;
                end else if (bytes == 2) begin
                    v = v & 32'hFFFF;
                    if (a.f3 < 3'd4 && v >= 32'h8000) v = v + 32'hFFFF_0000;
                end
                e.rdat = v;
            end
        end
        return e;
    endfunction

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input int gw, input int rw,
                                 input int stall, input logic exc, input logic [31:0] rdat,
                                 input logic [3:0] strb, input logic [31:0] wdata);
        vec_t v;
        v.a.rd = rd; v.a.wr = wr; v.a.f3 = f3; v.a.addr = addr; v.a.wd = wd;
        v.a.rdata = rdata; v.a.gw = gw; v.a.rw = rw;
        v.e.stall = stall; v.e.exc = exc; v.e.berr = 1'b0; v.e.rdat = rdat;
        v.e.ld = rd; v.e.req = !exc; v.e.maddr = addr & 32'hFFFF_FFFC; v.e.we = wr;
        v.e.wdata = wdata; v.e.strb = strb;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic run_access(input acc_t a, output res_t r);
        int   req_idx;
        int   k;
        logic granted;
        logic done;
        r.stall = 0; r.exc_done = 0; r.exc_n = 0; r.berr_done = 0; r.berr_n = 0;
        r.rdat = 0; r.req_n = 0; r.maddr = 0; r.we = 0; r.wdata = 0; r.strb = 0;
        r.unstable = 0; r.hung = 0;
        req_idx = 0; k = 0; granted = 0; done = 0;
        MemReadM = a.rd; MemWriteM = a.wr; funct3M = a.f3;
        ALUResultM = a.addr; WriteDataM = a.wd;
        for (int cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge clk);
            if (cyc > 0 && !StallMemM) begin
                done        = 1;
                r.exc_done  = ExcM;
                r.berr_done = BusErrM;
                r.rdat      = ReadDataM;
            end
            if (ExcM)      r.exc_n++;
            if (BusErrM)   r.berr_n++;
            if (StallMemM) r.stall++;
            if (!done) begin
                mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
                if (mem_req) begin
                    if (r.req_n == 0) begin
                        r.maddr = mem_addr; r.we = mem_we; r.wdata = mem_wdata; r.strb = mem_wstrb;
                    end else if (mem_addr !== r.maddr || mem_we !== r.we ||
                                 mem_wdata !== r.wdata || mem_wstrb !== r.strb) begin
                        r.unstable = 1;
                    end
                    r.req_n++;
                    if (req_idx >= a.gw) begin
                        mem_gnt = 1'b1; granted = 1; k = 0;
                        if (a.rw == 0) mem_rvalid = 1'b1;
                    end
                    req_idx++;
                end else if (granted) begin
                    k++;
                    if (k == a.rw) mem_rvalid = 1'b1;
                end
                if (mem_rvalid) mem_rdata = a.rdata;
            end
        end
        if (!done) r.hung = 1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic compare(input string tag, input res_t r, input exp_t e);
        chk({tag, "_bound"}, r.hung, 1'b0);
        chk({tag, "_stall"}, r.stall, e.stall);
        chk({tag, "_exc"}, r.exc_done, e.exc);
        chk({tag, "_exc_pulses"}, r.exc_n, e.exc ? 1 : 0);
        chk({tag, "_berr"}, r.berr_done, e.berr);
        chk({tag, "_berr_pulses"}, r.berr_n, e.berr ? 1 : 0);
        chk({tag, "_req_seen"}, r.req_n > 0, e.req);
        if (e.ld || e.exc) chk({tag, "_rdata"}, r.rdat, e.rdat);
        if (e.req) begin
            chk({tag, "_addr"}, r.maddr, e.maddr);
            chk({tag, "_we"}, r.we, e.we);
            chk({tag, "_wstrb"}, r.strb, e.strb);
            if (e.we) chk({tag, "_wdata"}, r.wdata, e.wdata);
            chk({tag, "_stable"}, r.unstable, 1'b0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {StallMemM, ExcM, BusErrM, mem_req, mem_we, mem_wstrb}, 32'h0);
        chk({tag, "_addr"}, mem_addr, 32'h0);
        chk({tag, "_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_rdata"}, ReadDataM, 32'h0);
    endtask

    vec_t vecs[15];

    initial begin
        acc_t a;
        res_t r;
        exp_t e;

        vecs[0]  = mkv(1, 0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 2, 4, 0, 32'hDEADBEEF, 4'h0, 32'h0);
        vecs[1]  = mkv(1, 0, 3'd0, 32'h103, 32'h0,        32'h80123456, 0, 0, 2, 0, 32'hFFFFFF80, 4'h0, 32'h0);
        vecs[2]  = mkv(1, 0, 3'd4, 32'h103, 32'h0,        32'h80ABCDEF, 1, 1, 4, 0, 32'h00000080, 4'h0, 32'h0);
        vecs[3]  = mkv(1, 0, 3'd1, 32'h102, 32'h0,        32'h80015555, 0, 1, 3, 0, 32'hFFFF8001, 4'h0, 32'h0);
        vecs[4]  = mkv(0, 1, 3'd1, 32'h006, 32'hABCD1234, 32'h0,        0, 0, 2, 0, 32'h0, 4'hC, 32'h12341234);
        vecs[5]  = mkv(1, 0, 3'd2, 32'h101, 32'h0,        32'h11111111, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0);
        vecs[6]  = mkv(0, 1, 3'd0, 32'h001, 32'hFFFFFF55, 32'h0,        2, 0, 4, 0, 32'h0, 4'h2, 32'h55555555);
        vecs[7]  = mkv(1, 0, 3'd5, 32'h002, 32'h0,        32'h80017777, 0, 0, 2, 0, 32'h00008001, 4'h0, 32'h0);
        vecs[8]  = mkv(1, 1, 3'd2, 32'h010, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0, 4'h0, 32'h0);
        vecs[9]  = mkv(1, 0, 3'd3, 32'h010, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0, 4'h0, 32'h0);
        vecs[10] = mkv(0, 1, 3'd4, 32'h010, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0, 4'h0, 32'h0);
        vecs[11] = mkv(0, 1, 3'd2, 32'h200, 32'hCAFEF00D, 32'h0,        0, 3, 5, 0, 32'h0, 4'hF, 32'hCAFEF00D);
        vecs[12] = mkv(1, 0, 3'd1, 32'h001, 32'h0,        32'h0,        0, 0, 0, 1, 32'h0, 4'h0, 32'h0);
        vecs[13] = mkv(1, 0, 3'd0, 32'h001, 32'h0,        32'h00007F00, 0, 0, 2, 0, 32'h0000007F, 4'h0, 32'h0);
        vecs[14] = mkv(1, 0, 3'd1, 32'h000, 32'h0,        32'h1234FFFE, 0, 0, 2, 0, 32'hFFFFFFFE, 4'h0, 32'h0);

        rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
        ALUResultM = 32'h0; WriteDataM = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset");
        @(posedge clk); #1;

        // Directed table, issued back to back.
        for (int i = 0; i < 15; i++) begin
            run_access(vecs[i].a, r);
            compare($sformatf("vec%0d", i), r, vecs[i].e);
        end

        // Bus never grants: timeout, then a stray late response must be ignored.
        a.rd = 1; a.wr = 0; a.f3 = 3'd2; a.addr = 32'h40; a.wd = 0;
        a.rdata = 32'hA5A5A5A5; a.gw = 1000; a.rw = 0;
        e = model(a);
        run_access(a, r);
        compare("timeout", r, e);
        chk("timeout_req_cycles", r.req_n, TIMEOUT);
        @(negedge clk);
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h87654321;
        @(negedge clk);
        chk_quiet("late_rvalid");
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk_quiet("late_rvalid_after");
        @(posedge clk); #1;

        // Reset while waiting for a response, then a late response after release.
        MemReadM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h80;
        @(negedge clk);
        chk("rstseq_idle_stall", StallMemM, 1'b1);
        @(negedge clk);
        chk("rstseq_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rstseq_wait_stall", {StallMemM, mem_req}, 2'b10);
        rst_n = 1'b0;
        MemReadM = 1'b0;
        @(negedge clk);
        chk_quiet("rstseq_in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk_quiet("rstseq_late_rvalid");
        @(negedge clk);
        chk_quiet("rstseq_after");
        @(posedge clk); #1;

        // Random accesses against the model, with occasional idle gaps.
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            a.rd = (sel <= 5);
            a.wr = (sel == 0) || (sel >= 6);
            a.f3 = 3'($urandom_range(0, 7));
            a.addr = $urandom;
            if ($urandom_range(0, 2) != 0) a.addr = a.addr & 32'hFFFF_FFFC;
            a.wd = $urandom;
            a.rdata = $urandom;
            a.gw = int'($urandom_range(0, 3));
            a.rw = int'($urandom_range(0, 3));
            e = model(a);
            run_access(a, r);
            compare($sformatf("rnd%0d", i), r, e);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(negedge clk);
        chk("tail_pulses", {ExcM, BusErrM, StallMemM, mem_req}, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
